// File: rtl/sccpu_dbus_pkg.sv
// Shared definitions for the single-cycle CPU data bus: I/O map, timer control
// bit positions and the read-select code used by the load-data mux.
package sccpu_dbus_pkg;

   localparam logic [15:0] IO_PAGE   = 16'hFFFF;
   localparam logic [31:0] IO_BASE   = 32'hFFFF_0000;
   localparam logic [15:0] OFF_LED   = 16'h0000;
   localparam logic [15:0] OFF_SEG   = 16'h0004;
   localparam logic [15:0] OFF_SW    = 16'h0008;
   localparam logic [15:0] OFF_TCTRL = 16'h0010;
   localparam logic [15:0] OFF_TLOAD = 16'h0014;
   localparam logic [15:0] OFF_TCNT  = 16'h0018;

   localparam int unsigned TC_EN   = 0;
   localparam int unsigned TC_AR   = 1;
   localparam int unsigned TC_STAT = 2;
   localparam int unsigned TC_IE   = 3;

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_LED,
      SEL_SEG,
      SEL_SW,
      SEL_TCTRL,
      SEL_TLOAD,
      SEL_TCNT,
      SEL_NONE
   } rd_sel_e;

   // Maps an address in the I/O page to its register; anything else is unmapped.
   function automatic rd_sel_e io_decode(input logic [15:0] page, input logic [13:0] word_off);
      rd_sel_e sel;
      sel = SEL_NONE;
      if (page == IO_PAGE) begin
         case ({word_off, 2'b00})
            OFF_LED:   sel = SEL_LED;
            OFF_SEG:   sel = SEL_SEG;
            OFF_SW:    sel = SEL_SW;
            OFF_TCTRL: sel = SEL_TCTRL;
            OFF_TLOAD: sel = SEL_TLOAD;
            OFF_TCNT:  sel = SEL_TCNT;
            default:   sel = SEL_NONE;
         endcase
      end else begin
         sel = SEL_NONE;
      end
      return sel;
   endfunction

endpackage

// File: rtl/dbus_timer.sv
// Memory-mapped down-counting timer: control/status, reload value, live count
// and a registered interrupt request (STAT & IE).
module dbus_timer
   import sccpu_dbus_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_ctrl,
   input  logic        wr_load,
   input  logic        clr_stat,
   input  logic [31:0] wdata,
   output logic [31:0] tctrl_rd,
   output logic [31:0] tload_rd,
   output logic [31:0] tcnt_rd,
   output logic        timer_irq
);

   logic        en_r, ar_r, ie_r, stat_r, irq_r;
   logic [31:0] tload_r, tcnt_r;
   logic        en_s, ar_s, ie_s, stat_s, expire_s;
   logic [31:0] tload_s, tcnt_s;

   // Next state: counting/expiry first, register writes take priority over it.
   always_comb begin
      expire_s = en_r && (tcnt_r == 32'd0);

      if (wr_load) begin
         tcnt_s = wdata;
      end else if (expire_s) begin
         tcnt_s = ar_r ? tload_r : 32'd0;
      end else if (en_r) begin
         tcnt_s = tcnt_r - 32'd1;
      end else begin
         tcnt_s = tcnt_r;
      end

      if (wr_ctrl) begin
         en_s = wdata[TC_EN];
      end else if (expire_s) begin
         en_s = ar_r;
      end else begin
         en_s = en_r;
      end

      ar_s    = wr_ctrl ? wdata[TC_AR] : ar_r;
      ie_s    = wr_ctrl ? wdata[TC_IE] : ie_r;
      tload_s = wr_load ? wdata : tload_r;

      // A coincident expiry beats a software clear so no event is lost.
      if (expire_s) begin
         stat_s = 1'b1;
      end else if (clr_stat) begin
         stat_s = 1'b0;
      end else begin
         stat_s = stat_r;
      end
   end

   // Timer state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         en_r    <= 1'b0;
         ar_r    <= 1'b0;
         ie_r    <= 1'b0;
         stat_r  <= 1'b0;
         irq_r   <= 1'b0;
         tload_r <= 32'd0;
         tcnt_r  <= 32'd0;
      end else begin
         en_r    <= en_s;
         ar_r    <= ar_s;
         ie_r    <= ie_s;
         stat_r  <= stat_s;
         irq_r   <= stat_s & ie_s;
         tload_r <= tload_s;
         tcnt_r  <= tcnt_s;
      end
   end

   assign tctrl_rd  = {28'd0, ie_r, stat_r, ar_r, en_r};
   assign tload_rd  = tload_r;
   assign tcnt_rd   = tcnt_r;
   assign timer_irq = irq_r;

endmodule

// File: rtl/sccpu_dbus.sv
// Data-side bus of the single-cycle CPU: zero-wait-state word RAM plus an I/O
// page with LED/7-seg outputs, synchronised switches and a timer.
module sccpu_dbus
   import sccpu_dbus_pkg::*;
#(
   parameter int unsigned DM_AW = 10,
   parameter int unsigned SW_W  = 16,
   parameter int unsigned LED_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   input  logic             we,
   output logic [31:0]      rdata,
   input  logic [SW_W-1:0]  sw_in,
   output logic [LED_W-1:0] led_out,
   output logic [31:0]      seg_out,
   output logic             timer_irq
);

   localparam int unsigned DM_DEPTH = 2**DM_AW;

   logic [31:0]      ram_r [DM_DEPTH];
   logic [DM_AW-1:0] ram_idx_s;
   logic             ram_hit_s;
   rd_sel_e          sel_s;
   logic [LED_W-1:0] led_r;
   logic [31:0]      seg_r;
   logic [SW_W-1:0]  sw_meta_r, sw_sync_r;
   logic             wr_ctrl_s, wr_load_s, clr_stat_s;
   logic [31:0]      tctrl_rd_s, tload_rd_s, tcnt_rd_s;
   logic             unused_lane_s;

   // Byte-lane bits carry no meaning: every access is a whole word.
   assign unused_lane_s = ^addr[1:0];

   assign ram_idx_s = addr[DM_AW+1:2];
   assign ram_hit_s = (addr[31:DM_AW+2] == '0);

   // Address decoder: RAM window first, then the I/O page.
   always_comb begin
      if (ram_hit_s) begin
         sel_s = SEL_RAM;
      end else begin
         sel_s = io_decode(addr[31:16], addr[15:2]);
      end
   end

   assign wr_ctrl_s  = we && (sel_s == SEL_TCTRL);
   assign wr_load_s  = we && (sel_s == SEL_TLOAD);
   assign clr_stat_s = wr_ctrl_s && wdata[TC_STAT];

   // Data RAM store port; contents survive reset.
   always_ff @(posedge clk) begin
      if (we && (sel_s == SEL_RAM)) begin
         ram_r[ram_idx_s] <= wdata;
      end
   end

   // LED/7-seg output registers and the two-flop switch synchroniser.
   always_ff @(posedge clk) begin
      if (!rst) begin
         led_r     <= '0;
         seg_r     <= 32'd0;
         sw_meta_r <= '0;
         sw_sync_r <= '0;
      end else begin
         sw_meta_r <= sw_in;
         sw_sync_r <= sw_meta_r;
         if (we && (sel_s == SEL_LED)) begin
            led_r <= wdata[LED_W-1:0];
         end
         if (we && (sel_s == SEL_SEG)) begin
            seg_r <= wdata;
         end
      end
   end

   dbus_timer u_timer (
      .clk       (clk),
      .rst       (rst),
      .wr_ctrl   (wr_ctrl_s),
      .wr_load   (wr_load_s),
      .clr_stat  (clr_stat_s),
      .wdata     (wdata),
      .tctrl_rd  (tctrl_rd_s),
      .tload_rd  (tload_rd_s),
      .tcnt_rd   (tcnt_rd_s),
      .timer_irq (timer_irq)
   );

   // Load-data mux, combinational from current state.
   always_comb begin
      rdata = 32'd0;
      case (sel_s)
         SEL_RAM:   rdata = ram_r[ram_idx_s];
         SEL_LED:   rdata = 32'(led_r);
         SEL_SEG:   rdata = seg_r;
         SEL_SW:    rdata = 32'(sw_sync_r);
         SEL_TCTRL: rdata = tctrl_rd_s;
         SEL_TLOAD: rdata = tload_rd_s;
         SEL_TCNT:  rdata = tcnt_rd_s;
         SEL_NONE:  rdata = 32'd0;
         default:   rdata = 32'd0;
      endcase
   end

   assign led_out = led_r;
   assign seg_out = seg_r;

endmodule
